// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, issues word requests over a
// req/gnt/rvalid bus and buffers returned words in an in-order FIFO for decode.
module fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        id_ready,
    output logic        id_valid,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic [24:0] id_raw_imm
);

    localparam int unsigned PW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW      = PW + 1;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_FLUSH = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic [CW-1:0] out_q, out_d;
    logic [CW-1:0] kill_q, kill_d;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] tag_rd_q, tag_rd_d;
    logic [PW-1:0] tag_wr_q, tag_wr_d;
    logic [31:0]   fifo_instr_q [FIFO_DEPTH];
    logic [31:0]   fifo_instr_d [FIFO_DEPTH];
    logic [31:0]   fifo_pc_q    [FIFO_DEPTH];
    logic [31:0]   fifo_pc_d    [FIFO_DEPTH];
    logic [31:0]   tag_q        [FIFO_DEPTH];
    logic [31:0]   tag_d        [FIFO_DEPTH];

    logic          pop;
    logic          push;
    logic          grant;
    logic [CW-1:0] occupancy;
    logic [CW-1:0] kill_next;

    // Low PC bits of a redirect target are discarded by design.
    logic unused_redirect_lsbs;
    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    // Decode-facing head of the buffer; NOP and PC 0 when empty.
    always_comb begin
        id_valid   = (count_q != '0);
        id_instr   = id_valid ? fifo_instr_q[rd_ptr_q] : NOP_INSTR;
        id_pc      = id_valid ? fifo_pc_q[rd_ptr_q] : 32'h0;
        id_raw_imm = id_instr[31:7];
    end

    // Request issue: only in FETCH, never during redirect, and only with room for the reply.
    always_comb begin
        pop       = id_valid & id_ready;
        occupancy = out_q + count_q - CW'(pop);
        imem_req  = (state_q == S_FETCH) & ~redirect & (occupancy < CW'(FIFO_DEPTH));
        imem_addr = pc_q;
        grant     = imem_req & imem_gnt;
        push      = imem_rvalid & (kill_q == '0) & (state_q != S_FLUSH) & (out_q != '0) & ~redirect;
    end

    // Next-state, PC, counters, tag queue and FIFO update; redirect overrides everything.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        out_d        = out_q;
        kill_d       = kill_q;
        count_d      = count_q;
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        tag_rd_d     = tag_rd_q;
        tag_wr_d     = tag_wr_q;
        fifo_instr_d = fifo_instr_q;
        fifo_pc_d    = fifo_pc_q;
        tag_d        = tag_q;
        kill_next    = '0;

        case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                if (redirect) begin
                    kill_next = out_q - CW'(imem_rvalid && (out_q != '0));
                    kill_d    = kill_next;
                    if (kill_next != '0) state_d = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (imem_rvalid && (kill_q != '0)) begin
                    kill_d = kill_q - CW'(1);
                    if (kill_q == CW'(1)) state_d = S_FETCH;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (grant) begin
            tag_d[tag_wr_q] = pc_q;
            tag_wr_d        = tag_wr_q + PW'(1);
            pc_d            = pc_q + 32'd4;
            out_d           = out_d + CW'(1);
        end

        if (push) begin
            fifo_instr_d[wr_ptr_q] = imem_rdata;
            fifo_pc_d[wr_ptr_q]    = tag_q[tag_rd_q];
            wr_ptr_d               = wr_ptr_q + PW'(1);
            tag_rd_d               = tag_rd_q + PW'(1);
            out_d                  = out_d - CW'(1);
        end

        if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
        count_d = count_q + CW'(push) - CW'(pop);

        if (redirect) begin
            pc_d     = {redirect_pc[31:2], 2'b00};
            out_d    = '0;
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            tag_rd_d = '0;
            tag_wr_d = '0;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            pc_q         <= RESET_PC;
            out_q        <= '0;
            kill_q       <= '0;
            count_q      <= '0;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            tag_rd_q     <= '0;
            tag_wr_q     <= '0;
            fifo_instr_q <= '{default: '0};
            fifo_pc_q    <= '{default: '0};
            tag_q        <= '{default: '0};
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            out_q        <= out_d;
            kill_q       <= kill_d;
            count_q      <= count_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            tag_rd_q     <= tag_rd_d;
            tag_wr_q     <= tag_wr_d;
            fifo_instr_q <= fifo_instr_d;
            fifo_pc_q    <= fifo_pc_d;
            tag_q        <= tag_d;
        end
    end

endmodule
